// File: rtl/module_ofm_collect_ctrl.sv
// Frame sequencer for the conv outcome-collection path: tracks raster position,
// forwards valid-window results to the OFM buffer with sequential addresses.
module module_ofm_collect_ctrl #(
   parameter int WIDTH  = 18,
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8,
   parameter int K      = 3,
   parameter int ADDR_W = 6
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [WIDTH-1:0]  in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [WIDTH-1:0]  out_data_o,
   output logic [ADDR_W-1:0] out_addr_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [1:0]        state_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   state_t            state_q, state_d;
   logic [RW-1:0]     row_q, row_d;
   logic [CW-1:0]     col_q, col_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic              out_valid_q, out_valid_d;
   logic [WIDTH-1:0]  out_data_q, out_data_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;

   logic accept, out_fire, keep, last_col, last_beat;

   // Handshake: a beat moves when valid && ready on the same rising edge; the
   // producer holds valid/data stable until then, the consumer may toggle ready.
   assign in_ready_o = (state_q == S_RUN) && (!out_valid_q || out_ready_i);
   assign accept     = in_valid_i && in_ready_o;
   assign out_fire   = out_valid_q && out_ready_i;
   assign keep       = (int'(row_q) >= K - 1) && (int'(col_q) >= K - 1);
   assign last_col   = (col_q == CW'(IMG_W - 1));
   assign last_beat  = last_col && (row_q == RW'(IMG_H - 1));

   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      col_d       = col_q;
      wr_addr_d   = wr_addr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_addr_d  = out_addr_q;

      // A kept beat below overrides this clear, so back-to-back writes have no bubble.
      if (out_fire) out_valid_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d   = S_RUN;
               row_d     = '0;
               col_d     = '0;
               wr_addr_d = '0;
            end
         end
         S_RUN: begin
            if (accept) begin
               if (last_col) begin
                  col_d = '0;
                  row_d = row_q + RW'(1);
               end else begin
                  col_d = col_q + CW'(1);
               end
               if (keep) begin
                  out_valid_d = 1'b1;
                  out_data_d  = in_data_i;
                  out_addr_d  = wr_addr_q;
                  wr_addr_d   = wr_addr_q + ADDR_W'(1);
               end
               if (last_beat) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!out_valid_q || out_fire) state_d = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         row_q       <= '0;
         col_q       <= '0;
         wr_addr_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         wr_addr_q   <= wr_addr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_addr_q  <= out_addr_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_addr_o  = out_addr_q;
   assign busy_o      = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done_o      = (state_q == S_DONE);
   assign state_o     = state_q;

endmodule

// File: tb/tb_module_ofm_collect_ctrl.sv
// Bench for module_ofm_collect_ctrl: 8x8/K=3 instance plus a 4x4/K=1 instance,
// expected writes queued at input acceptance and popped on each OFM handshake.
module tb_module_ofm_collect_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic in_valid = 1'b0;
   logic [17:0] in_data = '0;
   logic out_ready = 1'b1;
   logic sel = 1'b0;

   logic a_in_ready, a_out_valid, a_busy, a_done;
   logic [17:0] a_out_data;
   logic [5:0] a_out_addr;
   logic [1:0] a_state;
   logic b_in_ready, b_out_valid, b_busy, b_done;
   logic [17:0] b_out_data;
   logic [5:0] b_out_addr;
   logic [1:0] b_state;

   logic m_in_ready, m_out_valid, m_busy, m_done;
   logic [17:0] m_out_data;
   logic [5:0] m_out_addr;

   int checks = 0;
   int errors = 0;
   logic [23:0] exp_q[$];
   logic [5:0] exp_addr = '0;
   int n_writes = 0;
   int done_count = 0;
   int done_exp = 0;
   logic prev_last_hs = 1'b0;
   int cur_w = 8, cur_h = 8, cur_k = 3;
   bit gap_en = 0;
   bit rand_data = 0;

   always #5 clk = ~clk;

   module_ofm_collect_ctrl #(.WIDTH(18), .IMG_W(8), .IMG_H(8), .K(3), .ADDR_W(6)) u_dut_a (
      .clk_i(clk), .rst_i(rst), .start_i(start && !sel), .in_valid_i(in_valid),
      .in_ready_o(a_in_ready), .in_data_i(in_data), .out_valid_o(a_out_valid),
      .out_ready_i(out_ready), .out_data_o(a_out_data), .out_addr_o(a_out_addr),
      .busy_o(a_busy), .done_o(a_done), .state_o(a_state)
   );

   module_ofm_collect_ctrl #(.WIDTH(18), .IMG_W(4), .IMG_H(4), .K(1), .ADDR_W(6)) u_dut_b (
      .clk_i(clk), .rst_i(rst), .start_i(start && sel), .in_valid_i(in_valid),
      .in_ready_o(b_in_ready), .in_data_i(in_data), .out_valid_o(b_out_valid),
      .out_ready_i(out_ready), .out_data_o(b_out_data), .out_addr_o(b_out_addr),
      .busy_o(b_busy), .done_o(b_done), .state_o(b_state)
   );

   assign m_in_ready  = sel ? b_in_ready  : a_in_ready;
   assign m_out_valid = sel ? b_out_valid : a_out_valid;
   assign m_out_data  = sel ? b_out_data  : a_out_data;
   assign m_out_addr  = sel ? b_out_addr  : a_out_addr;
   assign m_busy      = sel ? b_busy      : a_busy;
   assign m_done      = sel ? b_done      : a_done;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic finish_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   endtask

   // Scoreboard consumer: every OFM handshake pops one expected {addr,data}.
   always @(negedge clk) begin
      if (!rst) begin
         logic hs_last;
         hs_last = 1'b0;
         if (m_out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("write_expected", 32'(0), 32'(1));
            end else begin
               logic [23:0] e;
               e = exp_q.pop_front();
               chk("write_addr", 32'(m_out_addr), 32'(e[23:18]));
               chk("write_data", 32'(m_out_data), 32'(e[17:0]));
               n_writes++;
            end
            hs_last = (int'(m_out_addr) == (cur_h - cur_k + 1) * (cur_w - cur_k + 1) - 1);
         end
         if (m_done) begin
            done_count++;
            chk("done_after_last_write", 32'(prev_last_hs), 32'(1));
            chk("busy_low_with_done", 32'(m_busy), 32'(0));
         end
         prev_last_hs = hs_last;
      end
   end

   task automatic push_expected(input int i, input logic [17:0] d);
      int r, c;
      r = i / cur_w;
      c = i % cur_w;
      if (r >= cur_k - 1 && c >= cur_k - 1) begin
         exp_q.push_back({exp_addr, d});
         exp_addr++;
      end
   endtask

   task automatic send_beats(input int n);
      for (int i = 0; i < n; i++) begin
         bit acc;
         int budget;
         while (gap_en && $urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data = rand_data ? 18'($urandom_range(0, 262143)) : 18'(i);
         acc = 0;
         budget = 0;
         while (!acc) begin
            @(negedge clk);
            if (m_in_ready) begin
               acc = 1;
               push_expected(i, in_data);
            end
            @(posedge clk); #1;
            budget++;
            if (budget > 300) begin
               chk("accept_timeout", 32'(0), 32'(1));
               finish_run();
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic start_frame();
      exp_q.delete();
      exp_addr = '0;
      n_writes = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_start", 32'(m_busy), 32'(1));
   endtask

   task automatic wait_done(input int total, input bit pulse_start);
      int budget;
      budget = 0;
      while (1) begin
         @(posedge clk); #2;
         if (m_done) break;
         budget++;
         if (budget > 500) begin
            chk("done_timeout", 32'(0), 32'(1));
            finish_run();
         end
      end
      done_exp++;
      if (pulse_start) start = 1'b1;
      chk("writes_per_frame", 32'(n_writes), 32'(total));
      chk("queue_empty_at_done", 32'(exp_q.size()), 32'(0));
      @(posedge clk); #2;
      start = 1'b0;
      chk("done_one_cycle", 32'(m_done), 32'(0));
      chk("busy_after_done", 32'(m_busy), 32'(0));
      @(posedge clk); #2;
      chk("idle_stays_idle", 32'(m_busy), 32'(0));
      chk("done_count", 32'(done_count), 32'(done_exp));
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(a_out_valid), 32'(0));
      chk("rst_out_data", 32'(a_out_data), 32'(0));
      chk("rst_out_addr", 32'(a_out_addr), 32'(0));
      chk("rst_busy", 32'(a_busy), 32'(0));
      chk("rst_done", 32'(a_done), 32'(0));
      chk("rst_in_ready", 32'(a_in_ready), 32'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      // Test 1: back-to-back, always ready
      start_frame();
      send_beats(64);
      wait_done(36, 0);

      // Test 2: backpressure after the first write
      start_frame();
      fork
         send_beats(64);
         begin
            int budget;
            budget = 0;
            while (1) begin
               @(posedge clk); #1;
               if (m_out_valid) break;
               budget++;
               if (budget > 200) begin
                  chk("first_write_timeout", 32'(0), 32'(1));
                  finish_run();
               end
            end
            out_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
               #2;
               chk("stall_valid", 32'(m_out_valid), 32'(1));
               chk("stall_data", 32'(m_out_data), 32'(18));
               chk("stall_addr", 32'(m_out_addr), 32'(0));
               chk("stall_in_ready", 32'(m_in_ready), 32'(0));
               @(posedge clk); #1;
            end
            out_ready = 1'b1;
         end
      join
      wait_done(36, 0);

      // Test 3: random input gaps
      gap_en = 1;
      start_frame();
      send_beats(64);
      wait_done(36, 0);
      gap_en = 0;

      // Test 4: reset after 30 accepted beats, then a clean frame
      start_frame();
      send_beats(30);
      rst = 1'b1;
      #1;
      chk("abort_out_valid", 32'(m_out_valid), 32'(0));
      chk("abort_out_data", 32'(m_out_data), 32'(0));
      chk("abort_out_addr", 32'(m_out_addr), 32'(0));
      chk("abort_busy", 32'(m_busy), 32'(0));
      chk("abort_done", 32'(m_done), 32'(0));
      chk("abort_in_ready", 32'(m_in_ready), 32'(0));
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("abort_no_done", 32'(done_count), 32'(done_exp));
      #1;
      start_frame();
      send_beats(64);
      wait_done(36, 0);

      // Test 5: start pulses during RUN and DONE are ignored
      start_frame();
      fork
         send_beats(64);
         begin
            repeat (20) @(posedge clk);
            #1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
         end
      join
      wait_done(36, 1);

      // Test 6: K=1, 4x4 pass-through with addressing
      @(posedge clk); #1;
      sel = 1'b1;
      cur_w = 4;
      cur_h = 4;
      cur_k = 1;
      rand_data = 1;
      start_frame();
      send_beats(16);
      wait_done(16, 0);

      finish_run();
   end

endmodule
